// File: rtl/line_refill_responder_pkg.sv
// Shared cache-model package.
// Holds the cache line size shared with the cache model, the derivations
// used to size the refill burst (beat count, word and line offset widths)
// and the refill state enum.
package cache_sim_pkg;

  // Line size used by the set-associative cache model; the responder
  // must be built with the same value.
  localparam int CACHE_LINE_SIZE = 32;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} refill_state_t;

  // Number of bus beats in one line.
  function automatic int beats_of(int line_size, int bus_bytes);
    return line_size / bus_bytes;
  endfunction

  // Byte-offset width inside one beat.
  function automatic int wb_of(int bus_bytes);
    return $clog2(bus_bytes);
  endfunction

  // Byte-offset width inside one line.
  function automatic int ob_of(int line_size);
    return $clog2(line_size);
  endfunction

  // Width of a beat index; never narrower than one bit.
  function automatic int idx_w(int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic bit is_pow2(int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/line_refill_responder_if.sv
// Refill request / response bundle between the cache model (master) and
// the line refill responder (slave).
//   req_valid_41 / req_ready_41 / req_addr_41 : miss request handshake
//   rsp_valid_41 / rsp_ready_41               : response beat handshake
//   rsp_data_41, rsp_beat_41, rsp_last_41     : beat payload, word index, last flag
interface line_refill_responder_if #(
  parameter int ADDR_W    = 31,
  parameter int BUS_BYTES = 4,
  parameter int LINE_SIZE = 32
);
  import cache_sim_pkg::*;

  localparam int DATA_W = 8 * BUS_BYTES;
  localparam int BEAT_W = idx_w(beats_of(LINE_SIZE, BUS_BYTES));

  logic              req_valid_41;
  logic [ADDR_W-1:0] req_addr_41;
  logic              req_ready_41;
  logic              rsp_valid_41;
  logic              rsp_ready_41;
  logic [DATA_W-1:0] rsp_data_41;
  logic [BEAT_W-1:0] rsp_beat_41;
  logic              rsp_last_41;

  modport master (
    output req_valid_41, req_addr_41, rsp_ready_41,
    input  req_ready_41, rsp_valid_41, rsp_data_41, rsp_beat_41, rsp_last_41
  );

  modport slave (
    input  req_valid_41, req_addr_41, rsp_ready_41,
    output req_ready_41, rsp_valid_41, rsp_data_41, rsp_beat_41, rsp_last_41
  );
endinterface

// File: rtl/line_refill_responder_cwf_beat_seq.sv
// Critical-word-first beat sequencer.
// A loadable wrap-around beat index (mod BEATS) plus a beats-left down
// counter; the index starts at the requested word and wraps to word 0.
//   clk_41, rst_41 : clock, asynchronous active-low reset
//   load, start    : restart the sequence at word 'start'
//   advance        : one beat has been taken by the consumer
//   beat_idx       : word index of the current beat
//   last           : current beat is the final one of the line
module cwf_beat_seq #(
  parameter int BEATS = 8,
  parameter int IW    = 3
) (
  input  logic          clk_41,
  input  logic          rst_41,
  input  logic          load,
  input  logic [IW-1:0] start,
  input  logic          advance,
  output logic [IW-1:0] beat_idx,
  output logic          last
);
  localparam logic [IW-1:0] TOP = IW'(BEATS - 1);

  logic [IW-1:0] idx_reg;
  logic [IW-1:0] left_reg;

  always_ff @(posedge clk_41 or negedge rst_41) begin
    if (!rst_41) begin
      idx_reg  <= '0;
      left_reg <= '0;
    end else if (load) begin
      idx_reg  <= start;
      left_reg <= TOP;
    end else if (advance) begin
      idx_reg <= (idx_reg == TOP) ? '0 : idx_reg + 1'b1;
      if (left_reg != '0) begin
        left_reg <= left_reg - 1'b1;
      end
    end
  end

  assign beat_idx = idx_reg;
  assign last     = (left_reg == '0);
endmodule

// File: rtl/line_refill_responder.sv
// Memory-side line refill responder.
// Accepts one miss address, waits LATENCY cycles, then returns the whole
// line as a critical-word-first burst. Beat data is the byte address of
// the beat, so no storage is needed.
//   clk_41, rst_41 : clock, asynchronous active-low reset
//   bus (slave)    : request / response handshake bundle
//   refills_41     : completed bursts, free-running 31-bit count
module line_refill_responder
  import cache_sim_pkg::*;
#(
  parameter int LINE_SIZE = CACHE_LINE_SIZE,
  parameter int BUS_BYTES = 4,
  parameter int LATENCY   = 8,
  parameter int ADDR_W    = 31
) (
  input  logic                   clk_41,
  input  logic                   rst_41,
  line_refill_responder_if.slave bus,
  output logic [30:0]            refills_41
);
  localparam int BEATS  = beats_of(LINE_SIZE, BUS_BYTES);
  localparam int WB     = wb_of(BUS_BYTES);
  localparam int OB     = ob_of(LINE_SIZE);
  localparam int IW     = idx_w(BEATS);
  localparam int DATA_W = 8 * BUS_BYTES;
  localparam int LW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  generate
    if (LINE_SIZE != CACHE_LINE_SIZE) begin : g_bad_line
      $error("LINE_SIZE differs from the cache model line size");
    end
    if (!is_pow2(BUS_BYTES) || !is_pow2(LINE_SIZE)) begin : g_bad_pow2
      $error("BUS_BYTES and LINE_SIZE must be powers of two");
    end
    if (BUS_BYTES > LINE_SIZE || (LINE_SIZE % BUS_BYTES) != 0) begin : g_bad_div
      $error("BUS_BYTES must divide LINE_SIZE");
    end
    if (LATENCY < 1) begin : g_bad_lat
      $error("LATENCY must be at least 1");
    end
    if (ADDR_W <= OB) begin : g_bad_addr
      $error("ADDR_W too narrow for the line offset");
    end
  endgenerate

  refill_state_t     state_reg;
  logic [LW-1:0]     wait_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [IW-1:0]     start_reg;
  logic              valid_reg;
  logic [30:0]       refills_reg;

  logic              req_fire;
  logic              beat_fire;
  logic              seq_load;
  logic [IW-1:0]     req_start;
  logic [IW-1:0]     beat_idx;
  logic              beat_last;
  logic [ADDR_W-1:0] beat_addr;

  // Ready is forced low while reset is asserted, independent of state.
  assign bus.req_ready_41 = rst_41 && (state_reg == IDLE);
  assign req_fire         = bus.req_valid_41 && bus.req_ready_41;
  assign beat_fire        = valid_reg && bus.rsp_ready_41;
  assign seq_load         = (state_reg == WAIT) && (wait_reg == '0);

  generate
    if (BEATS > 1) begin : g_start
      assign req_start = bus.req_addr_41[OB-1:WB];
    end else begin : g_start_one
      assign req_start = '0;
    end
  endgenerate

  always_ff @(posedge clk_41 or negedge rst_41) begin
    if (!rst_41) begin
      state_reg   <= IDLE;
      wait_reg    <= '0;
      base_reg    <= '0;
      start_reg   <= '0;
      valid_reg   <= 1'b0;
      refills_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_fire) begin
            base_reg  <= bus.req_addr_41 & ~ADDR_W'(LINE_SIZE - 1);
            start_reg <= req_start;
            wait_reg  <= LW'(LATENCY - 1);
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (wait_reg == '0) begin
            valid_reg <= 1'b1;
            state_reg <= BURST;
          end else begin
            wait_reg <= wait_reg - 1'b1;
          end
        end
        BURST: begin
          if (beat_fire && beat_last) begin
            valid_reg   <= 1'b0;
            refills_reg <= refills_reg + 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  cwf_beat_seq #(
    .BEATS (BEATS),
    .IW    (IW)
  ) u_seq (
    .clk_41   (clk_41),
    .rst_41   (rst_41),
    .load     (seq_load),
    .start    (start_reg),
    .advance  (beat_fire),
    .beat_idx (beat_idx),
    .last     (beat_last)
  );

  // The line base has its offset bits cleared, so OR-ing in the word
  // offset is the same as adding it.
  assign beat_addr = base_reg | (ADDR_W'(beat_idx) << WB);

  assign bus.rsp_valid_41 = valid_reg;
  assign bus.rsp_data_41  = valid_reg ? DATA_W'(beat_addr) : '0;
  assign bus.rsp_beat_41  = valid_reg ? beat_idx : '0;
  assign bus.rsp_last_41  = valid_reg && beat_last;
  assign refills_41       = refills_reg;
endmodule

// File: tb/tb_line_refill_responder.sv
module tb_line_refill_responder;
  localparam int LINE_SIZE = 32;
  localparam int BUS_BYTES = 4;
  localparam int LATENCY   = 3;
  localparam int ADDR_W    = 31;
  localparam int BEATS     = LINE_SIZE / BUS_BYTES;
  localparam int SPACING   = LATENCY + BEATS + 1;

  logic        clk_41 = 1'b0;
  logic        rst_41 = 1'b0;
  logic [30:0] refills_41;

  always #5 clk_41 = ~clk_41;

  line_refill_responder_if #(
    .ADDR_W    (ADDR_W),
    .BUS_BYTES (BUS_BYTES),
    .LINE_SIZE (LINE_SIZE)
  ) bus ();

  line_refill_responder #(
    .LINE_SIZE (LINE_SIZE),
    .BUS_BYTES (BUS_BYTES),
    .LATENCY   (LATENCY),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk_41     (clk_41),
    .rst_41     (rst_41),
    .bus        (bus),
    .refills_41 (refills_41)
  );

  typedef struct {
    longint unsigned data;
    int              beat;
    bit              last;
  } beat_t;

  beat_t           exp_q[$];
  int              accept_cyc[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  bit              busy     = 0;
  int              since    = 0;
  int              cyc      = 0;
  int              burst_pops = 0;
  longint unsigned m_refills = 0;

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: a line is the BEATS word addresses of its aligned
  // block, starting at the requested word and wrapping around.
  task automatic push_line(longint unsigned addr);
    longint unsigned base;
    int              start;
    beat_t           b;
    base  = addr - (addr % LINE_SIZE);
    start = int'((addr % LINE_SIZE) / BUS_BYTES);
    for (int k = 0; k < BEATS; k++) begin
      b.beat = (start + k) % BEATS;
      b.data = base + longint'(b.beat) * BUS_BYTES;
      b.last = (k == BEATS - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk_41) begin
    beat_t e;
    cyc++;
    if (!rst_41) begin
      chk("rst_req_ready", bus.req_ready_41, 0);
      chk("rst_rsp_valid", bus.rsp_valid_41, 0);
      chk("rst_rsp_last",  bus.rsp_last_41,  0);
      chk("rst_rsp_data",  bus.rsp_data_41,  0);
      chk("rst_rsp_beat",  bus.rsp_beat_41,  0);
      chk("rst_refills",   refills_41,       0);
      exp_q.delete();
      busy      = 0;
      since     = 0;
      m_refills = 0;
    end else begin
      if (busy) since++;
      chk("req_ready", bus.req_ready_41, busy ? 0 : 1);
      chk("rsp_valid", bus.rsp_valid_41, (busy && since > LATENCY) ? 1 : 0);
      chk("refills",   refills_41,       m_refills);
      if (bus.rsp_valid_41) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          e = exp_q[0];
          chk("rsp_data", bus.rsp_data_41, e.data);
          chk("rsp_beat", bus.rsp_beat_41, longint'(e.beat));
          chk("rsp_last", bus.rsp_last_41, e.last ? 1 : 0);
          if (bus.rsp_ready_41) begin
            void'(exp_q.pop_front());
            burst_pops++;
            if (e.last) begin
              busy      = 0;
              m_refills = (m_refills + 1) % (64'd1 << 31);
            end
          end
        end
      end
      if (bus.req_valid_41 && bus.req_ready_41) begin
        push_line(longint'(bus.req_addr_41));
        accept_cyc.push_back(cyc);
        busy       = 1;
        since      = 0;
        burst_pops = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_41);
    #1;
  endtask

  task automatic send_req(logic [ADDR_W-1:0] a);
    bit got;
    got = 0;
    bus.req_valid_41 = 1'b1;
    bus.req_addr_41  = a;
    for (int i = 0; i < 100 && !got; i++) begin
      got = bus.req_ready_41;
      tick();
    end
    bus.req_valid_41 = 1'b0;
    if (!got) fail_now("req_accept_timeout");
  endtask

  task automatic wait_idle(int budget, bit rnd);
    for (int i = 0; i < budget; i++) begin
      if (!busy && exp_q.size() == 0) return;
      bus.rsp_ready_41 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    fail_now("burst_timeout");
  endtask

  task automatic wait_valid(int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.rsp_valid_41) return;
      tick();
    end
    fail_now("valid_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned r0;
    int              cnt;
    bus.req_valid_41 = 1'b0;
    bus.req_addr_41  = '0;
    bus.rsp_ready_41 = 1'b0;
    rst_41           = 1'b0;
    repeat (5) @(posedge clk_41);
    #1 rst_41 = 1'b1;
    tick();

    // Critical word 0x44 with an always-ready consumer.
    bus.rsp_ready_41 = 1'b1;
    send_req(31'h44);
    wait_idle(100, 0);
    chk("refills_first", refills_41, 1);

    // Consumer stalls for two cycles on the third beat (0x108).
    send_req(31'h100);
    wait_valid(50);
    tick();
    tick();
    bus.rsp_ready_41 = 1'b0;
    tick();
    tick();
    bus.rsp_ready_41 = 1'b1;
    wait_idle(100, 0);
    chk("refills_stall", refills_41, 2);

    // Requests during WAIT and BURST are ignored.
    send_req(31'h8C);
    bus.req_valid_41 = 1'b1;
    bus.req_addr_41  = 31'h200;
    tick();
    bus.req_valid_41 = 1'b0;
    wait_valid(50);
    tick();
    tick();
    bus.req_valid_41 = 1'b1;
    tick();
    tick();
    bus.req_valid_41 = 1'b0;
    wait_idle(100, 0);
    chk("refills_ignore", refills_41, 3);

    // Reset while the fourth beat is on the bus.
    send_req(31'h1A4);
    for (int i = 0; i < 50 && burst_pops < 3; i++) tick();
    if (burst_pops < 3) fail_now("fourth_beat_timeout");
    rst_41 = 1'b0;
    tick();
    tick();
    rst_41 = 1'b1;
    tick();
    chk("refills_after_reset", refills_41, 0);
    send_req(31'h2E8);
    wait_idle(100, 0);
    chk("refills_post_reset", refills_41, 1);

    // Back-to-back requests with valid held high.
    r0 = longint'(refills_41);
    accept_cyc.delete();
    cnt = 0;
    bus.rsp_ready_41 = 1'b1;
    bus.req_valid_41 = 1'b1;
    bus.req_addr_41  = 31'($urandom);
    for (int i = 0; i < 80 && cnt < 3; i++) begin
      bit got;
      got = bus.req_ready_41;
      tick();
      if (got) begin
        cnt++;
        bus.req_addr_41 = 31'($urandom);
      end
    end
    bus.req_valid_41 = 1'b0;
    wait_idle(100, 0);
    if (accept_cyc.size() != 3) begin
      chk("b2b_accepts", accept_cyc.size(), 3);
    end else begin
      chk("b2b_spacing_0", accept_cyc[1] - accept_cyc[0], SPACING);
      chk("b2b_spacing_1", accept_cyc[2] - accept_cyc[1], SPACING);
    end
    chk("b2b_refills", longint'(refills_41) - r0, 3);

    // Random addresses, gaps and consumer backpressure.
    for (int n = 0; n < 25; n++) begin
      bus.rsp_ready_41 = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      send_req(31'($urandom));
      wait_idle(400, 1);
    end
    bus.rsp_ready_41 = 1'b1;
    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
